// File: rtl/ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG command path and the Avalon-MM debug slave.
// Holds the JTAG auto-increment pointer and a one-entry command slot, and arbitrates round-robin per access.
module ocimem_access_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_set_addr,
  input  logic [ADDR_W-1:0] jtag_addr_in,
  input  logic              jtag_wr,
  input  logic              jtag_rd,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rvalid,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_jtag
);

  logic [ADDR_W-1:0] r_ptr;
  logic              r_slot_full;
  logic              r_slot_we;
  logic [ADDR_W-1:0] r_slot_addr;
  logic [DATA_W-1:0] r_slot_wdata;
  logic              r_last_jtag;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_avs_rdv;
  logic              r_jrd_p1;
  logic              r_jtag_rvalid;
  logic [DATA_W-1:0] r_jtag_rdata;

  logic              w_req_a;
  logic              w_req_j;
  logic              w_grant_j;
  logic              w_grant_a;
  logic              w_cmd;
  logic              w_slot_free;
  logic              w_drop;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;

  // Round-robin on ties: the side not granted last wins.
  assign w_req_a   = avs_read | avs_write;
  assign w_req_j   = r_slot_full;
  assign w_grant_j = w_req_j & (~w_req_a | ~r_last_jtag);
  assign w_grant_a = w_req_a & ~w_grant_j;

  // A same-cycle set_addr overrides the pointer for the command it accompanies.
  assign w_cmd       = jtag_rd | jtag_wr;
  assign w_cmd_addr  = jtag_set_addr ? jtag_addr_in : r_ptr;
  assign w_slot_free = ~r_slot_full | w_grant_j;
  assign w_drop      = (w_cmd & ~w_slot_free) | (jtag_rd & jtag_wr);

  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_we    = 1'b0;
    w_mem_wdata = avs_writedata;
    if (w_grant_j) begin
      w_mem_addr  = r_slot_addr;
      w_mem_we    = r_slot_we;
      w_mem_wdata = r_slot_wdata;
    end else if (w_grant_a) begin
      w_mem_addr  = avs_address;
      w_mem_we    = avs_write;
      w_mem_wdata = avs_writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr         <= '0;
      r_slot_full   <= 1'b0;
      r_slot_we     <= 1'b0;
      r_slot_addr   <= '0;
      r_slot_wdata  <= '0;
      r_last_jtag   <= 1'b0;
      r_overrun     <= 1'b0;
      r_mem_addr    <= '0;
      r_avs_rdv     <= 1'b0;
      r_jrd_p1      <= 1'b0;
      r_jtag_rvalid <= 1'b0;
      r_jtag_rdata  <= '0;
    end else begin
      r_mem_addr    <= w_mem_addr;
      if (w_grant_j | w_grant_a) r_last_jtag <= w_grant_j;
      r_avs_rdv     <= w_grant_a & avs_read & ~avs_write;
      r_jrd_p1      <= w_grant_j & ~r_slot_we;
      r_jtag_rvalid <= r_jrd_p1;
      if (r_jrd_p1) r_jtag_rdata <= mem_rdata;

      if (jtag_set_addr) r_ptr <= jtag_addr_in;
      if (w_grant_j) r_slot_full <= 1'b0;
      // A write wins over a simultaneous read; a full, ungranted slot keeps its entry.
      if (w_cmd && w_slot_free) begin
        r_slot_full  <= 1'b1;
        r_slot_we    <= jtag_wr;
        r_slot_addr  <= w_cmd_addr;
        r_slot_wdata <= jtag_wdata;
        r_ptr        <= w_cmd_addr + ADDR_W'(1);
      end

      if (jtag_set_addr) r_overrun <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign mem_addr          = w_mem_addr;
  assign mem_we            = w_mem_we;
  assign mem_wdata         = w_mem_wdata;
  assign grant_jtag        = w_grant_j;
  assign avs_waitrequest   = w_req_a & ~w_grant_a;
  assign avs_readdata      = mem_rdata;
  assign avs_readdatavalid = r_avs_rdv;
  assign jtag_rdata        = r_jtag_rdata;
  assign jtag_rvalid       = r_jtag_rvalid;
  assign jtag_busy         = r_slot_full;
  assign jtag_overrun      = r_overrun;

endmodule
